// File: rtl/ram_clear_writer.sv
// ram_clear_writer: sits in front of a synchronous single-port RAM and either
// passes client accesses straight through (IDLE) or sweeps a fixed value over
// addresses 0..DEPTH-1 (CLEAR), followed by a one-cycle completion pulse (DONE).
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | client owns the RAM port; clr_req starts a clear
//   CLEAR | one RAM write per cycle at address cnt, client stalled
//   DONE  | single cycle, clr_done pulses, no RAM write, then IDLE
module ram_clear_writer #(
  parameter int                 ADDRLEN       = 10,
  parameter int                 DATALEN       = 2,
  parameter int                 DEPTH         = 1024,
  parameter logic [DATALEN-1:0] CLRVAL        = '0,
  parameter bit                 INIT_ON_RESET = 1'b0
) (
  input  logic               clk,
  input  logic               reset_x,
  input  logic               clr_req,
  output logic               clr_busy,
  output logic               clr_done,
  input  logic               c_req,
  input  logic               c_we,
  input  logic [ADDRLEN-1:0] c_addr,
  input  logic [DATALEN-1:0] c_wdata,
  output logic               c_gnt,
  output logic               c_rvalid,
  output logic [DATALEN-1:0] c_rdata,
  output logic [ADDRLEN-1:0] ram_addr,
  output logic [DATALEN-1:0] ram_wdata,
  output logic               ram_we,
  input  logic [DATALEN-1:0] ram_rdata
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Last address swept; the counter stops here so unused addresses above
  // DEPTH-1 are never touched when DEPTH is not a power of two.
  localparam logic [ADDRLEN-1:0] LAST = ADDRLEN'(DEPTH - 1);

  state_t             state;
  state_t             state_nxt;
  logic [ADDRLEN-1:0] cnt;

  // State register; reset lands in CLEAR when an automatic clear is wanted.
  always_ff @(posedge clk or negedge reset_x) begin
    if (!reset_x) begin
      if (INIT_ON_RESET) state <= CLEAR;
      else               state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode; clr_req is only looked at in IDLE, so requests made
  // during CLEAR or DONE are dropped rather than queued.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (clr_req) state_nxt = CLEAR;
      CLEAR:   if (cnt == LAST) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Sweep address counter; parked at zero outside CLEAR so every clear
  // begins at address 0.
  always_ff @(posedge clk or negedge reset_x) begin
    if (!reset_x) begin
      cnt <= '0;
    end else if (state == CLEAR) begin
      if (cnt == LAST) cnt <= '0;
      else             cnt <= cnt + ADDRLEN'(1);
    end else begin
      cnt <= '0;
    end
  end

  // RAM port mux and status outputs; writes and grants are qualified by
  // reset_x so the RAM never sees a write strobe while reset is held.
  always_comb begin
    c_gnt     = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = c_addr;
    ram_wdata = c_wdata;
    clr_busy  = 1'b0;
    clr_done  = 1'b0;
    case (state)
      IDLE: begin
        c_gnt  = reset_x;
        ram_we = reset_x & c_req & c_we;
      end
      CLEAR: begin
        clr_busy  = 1'b1;
        ram_we    = reset_x;
        ram_addr  = cnt;
        ram_wdata = CLRVAL;
      end
      DONE: begin
        clr_busy = 1'b1;
        clr_done = 1'b1;
      end
      default: ;
    endcase
  end

  // Read-data valid follows a granted read by one cycle, matching the RAM's
  // registered read latency.
  always_ff @(posedge clk or negedge reset_x) begin
    if (!reset_x) c_rvalid <= 1'b0;
    else          c_rvalid <= c_gnt & c_req & ~c_we;
  end

  assign c_rdata = ram_rdata;

endmodule

// File: tb/tb_ram_clear_writer.sv
// Testbench for ram_clear_writer: three instances (DEPTH=8 main, DEPTH=5 with
// a 3-bit address, DEPTH=8 with INIT_ON_RESET=1) each driving a small RAM model.
// Expected RAM writes, read data and clr_done cycles are queued by the stimulus
// and consumed by per-instance monitors on the falling edge.
module tb_ram_clear_writer;

  logic clk;
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;

  // instance A: ADDRLEN=4, DEPTH=8, CLRVAL=0
  logic       rst_a, clr_req_a, c_req_a, c_we_a;
  logic [3:0] c_addr_a, ram_addr_a;
  logic [1:0] c_wdata_a, c_rdata_a, ram_wdata_a, ram_rdata_a;
  logic       clr_busy_a, clr_done_a, c_gnt_a, c_rvalid_a, ram_we_a;
  logic [1:0] mem_a [16];
  int wq_a[$], rq_a[$], dq_a[$];

  // instance B: ADDRLEN=3, DEPTH=5, CLRVAL=0
  logic       rst_b, clr_req_b, c_req_b, c_we_b;
  logic [2:0] c_addr_b, ram_addr_b;
  logic [1:0] c_wdata_b, c_rdata_b, ram_wdata_b, ram_rdata_b;
  logic       clr_busy_b, clr_done_b, c_gnt_b, c_rvalid_b, ram_we_b;
  logic [1:0] mem_b [8];
  int wq_b[$], rq_b[$], dq_b[$];

  // instance C: ADDRLEN=4, DEPTH=8, CLRVAL=1, INIT_ON_RESET=1
  logic       rst_c, clr_req_c, c_req_c, c_we_c;
  logic [3:0] c_addr_c, ram_addr_c;
  logic [1:0] c_wdata_c, c_rdata_c, ram_wdata_c, ram_rdata_c;
  logic       clr_busy_c, clr_done_c, c_gnt_c, c_rvalid_c, ram_we_c;
  logic [1:0] mem_c [16];
  int wq_c[$], dq_c[$];

  ram_clear_writer #(.ADDRLEN(4), .DATALEN(2), .DEPTH(8), .CLRVAL(2'd0), .INIT_ON_RESET(1'b0)) dut_a (
    .clk(clk), .reset_x(rst_a), .clr_req(clr_req_a), .clr_busy(clr_busy_a), .clr_done(clr_done_a),
    .c_req(c_req_a), .c_we(c_we_a), .c_addr(c_addr_a), .c_wdata(c_wdata_a),
    .c_gnt(c_gnt_a), .c_rvalid(c_rvalid_a), .c_rdata(c_rdata_a),
    .ram_addr(ram_addr_a), .ram_wdata(ram_wdata_a), .ram_we(ram_we_a), .ram_rdata(ram_rdata_a));

  ram_clear_writer #(.ADDRLEN(3), .DATALEN(2), .DEPTH(5), .CLRVAL(2'd0), .INIT_ON_RESET(1'b0)) dut_b (
    .clk(clk), .reset_x(rst_b), .clr_req(clr_req_b), .clr_busy(clr_busy_b), .clr_done(clr_done_b),
    .c_req(c_req_b), .c_we(c_we_b), .c_addr(c_addr_b), .c_wdata(c_wdata_b),
    .c_gnt(c_gnt_b), .c_rvalid(c_rvalid_b), .c_rdata(c_rdata_b),
    .ram_addr(ram_addr_b), .ram_wdata(ram_wdata_b), .ram_we(ram_we_b), .ram_rdata(ram_rdata_b));

  ram_clear_writer #(.ADDRLEN(4), .DATALEN(2), .DEPTH(8), .CLRVAL(2'd1), .INIT_ON_RESET(1'b1)) dut_c (
    .clk(clk), .reset_x(rst_c), .clr_req(clr_req_c), .clr_busy(clr_busy_c), .clr_done(clr_done_c),
    .c_req(c_req_c), .c_we(c_we_c), .c_addr(c_addr_c), .c_wdata(c_wdata_c),
    .c_gnt(c_gnt_c), .c_rvalid(c_rvalid_c), .c_rdata(c_rdata_c),
    .ram_addr(ram_addr_c), .ram_wdata(ram_wdata_c), .ram_we(ram_we_c), .ram_rdata(ram_rdata_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // cycle counter used to time clr_done pulses
  always @(posedge clk) cyc <= cyc + 1;

  // synchronous RAM models with one-cycle registered read
  always @(posedge clk) begin
    if (ram_we_a) mem_a[ram_addr_a] <= ram_wdata_a;
    ram_rdata_a <= mem_a[ram_addr_a];
    if (ram_we_b) mem_b[ram_addr_b] <= ram_wdata_b;
    ram_rdata_b <= mem_b[ram_addr_b];
    if (ram_we_c) mem_c[ram_addr_c] <= ram_wdata_c;
    ram_rdata_c <= mem_c[ram_addr_c];
  end

  task automatic check(input string nm, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic unexp(input string nm);
    vectors++;
    miscompares++;
    $display("FAIL %s: got an unexpected event, expected none (cycle %0d)", nm, cyc);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // monitor A: writes encoded as addr*4+data
  always @(negedge clk) begin
    if (rst_a) begin
      if (ram_we_a) begin
        if (wq_a.size() == 0) unexp("a_write");
        else check("a_write", int'(ram_addr_a) * 4 + int'(ram_wdata_a), wq_a.pop_front());
      end
      if (c_rvalid_a) begin
        if (rq_a.size() == 0) unexp("a_rvalid");
        else check("a_rdata", int'(c_rdata_a), rq_a.pop_front());
      end
      if (clr_done_a) begin
        if (dq_a.size() == 0) unexp("a_clr_done");
        else check("a_done_cycle", cyc, dq_a.pop_front());
      end
    end
  end

  // monitor B
  always @(negedge clk) begin
    if (rst_b) begin
      if (ram_we_b) begin
        if (wq_b.size() == 0) unexp("b_write");
        else check("b_write", int'(ram_addr_b) * 4 + int'(ram_wdata_b), wq_b.pop_front());
      end
      if (c_rvalid_b) begin
        if (rq_b.size() == 0) unexp("b_rvalid");
        else check("b_rdata", int'(c_rdata_b), rq_b.pop_front());
      end
      if (clr_done_b) begin
        if (dq_b.size() == 0) unexp("b_clr_done");
        else check("b_done_cycle", cyc, dq_b.pop_front());
      end
    end
  end

  // monitor C
  always @(negedge clk) begin
    if (rst_c) begin
      if (ram_we_c) begin
        if (wq_c.size() == 0) unexp("c_write");
        else check("c_write", int'(ram_addr_c) * 4 + int'(ram_wdata_c), wq_c.pop_front());
      end
      if (c_rvalid_c) unexp("c_rvalid");
      if (clr_done_c) begin
        if (dq_c.size() == 0) unexp("c_clr_done");
        else check("c_done_cycle", cyc, dq_c.pop_front());
      end
    end
  end

  // watchdog
  initial begin
    #50000;
    $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 16; i++) begin mem_a[i] = '0; mem_c[i] = '0; end
    for (int i = 0; i < 8; i++) mem_b[i] = '0;
    rst_a = 0; rst_b = 0; rst_c = 0;
    clr_req_a = 0; c_req_a = 1; c_we_a = 1; c_addr_a = 4'd5; c_wdata_a = 2'd1;
    clr_req_b = 0; c_req_b = 0; c_we_b = 0; c_addr_b = '0; c_wdata_b = '0;
    clr_req_c = 0; c_req_c = 0; c_we_c = 0; c_addr_c = '0; c_wdata_c = '0;
    repeat (3) tick();
    // reset state, with a client write held on A
    check("a_rst_ram_we", ram_we_a, 0);
    check("a_rst_busy", clr_busy_a, 0);
    check("a_rst_rvalid", c_rvalid_a, 0);
    check("a_rst_done", clr_done_a, 0);
    c_req_a = 0; c_we_a = 0;
    rst_a = 1; rst_b = 1;
    tick();

    // prefill A with 3 and B with 2
    for (int i = 0; i < 10; i++) begin
      c_req_a = 1; c_we_a = 1; c_addr_a = 4'(i); c_wdata_a = 2'd3;
      wq_a.push_back(i * 4 + 3);
      tick();
    end
    c_req_a = 0;
    for (int i = 0; i < 8; i++) begin
      c_req_b = 1; c_we_b = 1; c_addr_b = 3'(i); c_wdata_b = 2'd2;
      wq_b.push_back(i * 4 + 2);
      tick();
    end
    c_req_b = 0;
    tick();

    // A: clear accepted together with a read of address 2
    clr_req_a = 1; c_req_a = 1; c_we_a = 0; c_addr_a = 4'd2;
    rq_a.push_back(3);
    for (int i = 0; i < 8; i++) wq_a.push_back(i * 4);
    dq_a.push_back(cyc + 9);
    tick();
    // client write to 3 held through CLEAR and DONE
    clr_req_a = 0; c_we_a = 1; c_addr_a = 4'd3; c_wdata_a = 2'd1;
    for (int j = 0; j < 9; j++) begin
      #1;
      check("a_gnt_in_clear", c_gnt_a, 0);
      check("a_busy_in_clear", clr_busy_a, 1);
      tick();
    end
    #1;
    check("a_gnt_after_done", c_gnt_a, 1);
    check("a_busy_after_done", clr_busy_a, 0);
    wq_a.push_back(3 * 4 + 1);
    tick();

    // A: read back 0..9
    for (int i = 0; i < 10; i++) begin
      c_req_a = 1; c_we_a = 0; c_addr_a = 4'(i);
      rq_a.push_back(i == 3 ? 1 : (i >= 8 ? 3 : 0));
      tick();
    end
    c_req_a = 0;
    repeat (2) tick();

    // A: clr_req held 20 cycles -> two back-to-back clears
    dq_a.push_back(cyc + 9);
    dq_a.push_back(cyc + 19);
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 8; i++) wq_a.push_back(i * 4);
    clr_req_a = 1;
    repeat (20) tick();
    clr_req_a = 0;
    repeat (4) tick();

    // A: reset asserted when cnt reaches 4
    clr_req_a = 1;
    for (int i = 0; i < 4; i++) wq_a.push_back(i * 4);
    tick();
    clr_req_a = 0;
    repeat (4) tick();
    rst_a = 0;
    #1;
    check("a_abort_busy", clr_busy_a, 0);
    check("a_abort_we", ram_we_a, 0);
    check("a_abort_done", clr_done_a, 0);
    tick();
    rst_a = 1;
    tick();
    #1;
    check("a_after_abort_busy", clr_busy_a, 0);
    check("a_after_abort_gnt", c_gnt_a, 1);
    repeat (12) tick();

    // B: DEPTH=5 clear leaves addresses 5..7 untouched
    clr_req_b = 1;
    for (int i = 0; i < 5; i++) wq_b.push_back(i * 4);
    dq_b.push_back(cyc + 6);
    tick();
    clr_req_b = 0;
    repeat (8) tick();
    for (int i = 0; i < 8; i++) begin
      c_req_b = 1; c_we_b = 0; c_addr_b = 3'(i);
      rq_b.push_back(i < 5 ? 0 : 2);
      tick();
    end
    c_req_b = 0;
    repeat (2) tick();

    // C: automatic clear on reset release
    for (int i = 0; i < 8; i++) wq_c.push_back(i * 4 + 1);
    dq_c.push_back(cyc + 8);
    rst_c = 1;
    #1;
    check("c_gnt_auto_clear", c_gnt_c, 0);
    check("c_busy_auto_clear", clr_busy_c, 1);
    repeat (12) tick();
    // C: reset at cnt=4, clear restarts from address 0 on release
    rst_c = 0;
    tick();
    for (int i = 0; i < 4; i++) wq_c.push_back(i * 4 + 1);
    rst_c = 1;
    repeat (4) tick();
    rst_c = 0;
    #1;
    check("c_abort_done", clr_done_c, 0);
    tick();
    for (int i = 0; i < 8; i++) wq_c.push_back(i * 4 + 1);
    dq_c.push_back(cyc + 8);
    rst_c = 1;
    repeat (12) tick();

    // everything queued must have been seen
    check("a_writes_left", wq_a.size(), 0);
    check("a_reads_left", rq_a.size(), 0);
    check("a_dones_left", dq_a.size(), 0);
    check("b_writes_left", wq_b.size(), 0);
    check("b_reads_left", rq_b.size(), 0);
    check("b_dones_left", dq_b.size(), 0);
    check("c_writes_left", wq_c.size(), 0);
    check("c_dones_left", dq_c.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
